// File: rtl/seg_pkg.sv
// Shared definitions for the multiplexed seven-segment scan controller:
// segment bit order, hex glyph table, blank constant and handshake states.
package seg_pkg;

  // Segment bit positions within the 8-bit Segs bus {dp,g,f,e,d,c,b,a}
  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  // All segments dark, expressed active-high
  localparam logic [7:0] SEG_OFF = 8'h00;

  // Active-high glyphs {g,f,e,d,c,b,a} for 0-9, A, b, C, d, E, F
  localparam logic [6:0] GLYPHS [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  // Load handshake: idle (Ready high) or holding data for the next frame
  typedef enum logic {
    HS_IDLE    = 1'b0,
    HS_PENDING = 1'b1
  } hsState_t;

endpackage

// File: rtl/seg_hex_decoder.sv
// Combinational hex nibble to active-high 7-segment glyph lookup.
module seg_hex_decoder
  import seg_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_glyph
);

  assign o_glyph = GLYPHS[i_nibble];

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed seven-segment scan controller: prescaled tick, 16 sub-slots
// per digit for PWM brightness, frame-synchronous double-buffered data load.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int DIGITS     = 6,
  parameter int CLK_DIV    = 50000,
  parameter bit ACTIVE_LOW = 1'b1
)(
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  Load,
  input  logic [4*DIGITS-1:0]   Data,
  input  logic [DIGITS-1:0]     Points,
  input  logic [DIGITS-1:0]     DisplayEnables,
  input  logic [3:0]            Duty,
  output logic                  Ready,
  output logic                  FrameDone,
  output logic [DIGITS-1:0]     En,
  output logic [7:0]            Segs
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [PW-1:0]     PRESC_LAST    = PW'(CLK_DIV - 1);
  localparam logic [IW-1:0]     IDX_LAST      = IW'(DIGITS - 1);
  localparam logic [DIGITS-1:0] EN_INACTIVE   = {DIGITS{ACTIVE_LOW}};
  localparam logic [7:0]        SEGS_INACTIVE = ACTIVE_LOW ? ~SEG_OFF : SEG_OFF;

  logic [PW-1:0]       r_presc;
  logic [3:0]          r_sub;
  logic [IW-1:0]       r_idx;
  logic [4*DIGITS-1:0] r_pendData;
  logic [DIGITS-1:0]   r_pendPts;
  logic [4*DIGITS-1:0] r_dispData;
  logic [DIGITS-1:0]   r_dispPts;
  logic                r_frameDone;
  logic [DIGITS-1:0]   r_en;
  logic [7:0]          r_segs;
  hsState_t            r_hsState;
  hsState_t            w_hsNext;

  logic                w_tick;
  logic                w_slotWrap;
  logic                w_frameWrap;
  logic [3:0]          w_nibble;
  logic                w_point;
  logic                w_enabled;
  logic [DIGITS-1:0]   w_enOneHot;
  logic                w_lit;
  logic [6:0]          w_glyph;

  assign w_tick      = (r_presc == PRESC_LAST);
  assign w_slotWrap  = w_tick && (r_sub == 4'hF);
  assign w_frameWrap = w_slotWrap && (r_idx == IDX_LAST);

  // Scan timebase: prescaler, sub-slot counter and digit index
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_presc <= '0;
      r_sub   <= '0;
      r_idx   <= '0;
    end else if (w_tick) begin
      r_presc <= '0;
      r_sub   <= r_sub + 4'd1;
      if (r_sub == 4'hF) begin
        r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
      end
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

  // Pick the current digit's nibble, point, enable and strobe position
  always_comb begin
    w_nibble   = '0;
    w_point    = 1'b0;
    w_enabled  = 1'b0;
    w_enOneHot = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_idx == IW'(i)) begin
        w_nibble      = r_dispData[4*i +: 4];
        w_point       = r_dispPts[i];
        w_enabled     = DisplayEnables[i];
        w_enOneHot[i] = 1'b1;
      end
    end
  end

  assign w_lit = w_enabled && (r_sub < Duty);

  seg_hex_decoder u_decoder (
    .i_nibble (w_nibble),
    .o_glyph  (w_glyph)
  );

  // Registered, polarity-adjusted strobes and segments (blank when unlit)
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_en   <= EN_INACTIVE;
      r_segs <= SEGS_INACTIVE;
    end else if (w_lit) begin
      r_en   <= w_enOneHot ^ EN_INACTIVE;
      r_segs <= {w_point, w_glyph} ^ SEGS_INACTIVE;
    end else begin
      r_en   <= EN_INACTIVE;
      r_segs <= SEGS_INACTIVE;
    end
  end

  // Handshake state register
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_hsState <= HS_IDLE;
    end else begin
      r_hsState <= w_hsNext;
    end
  end

  // Handshake next state: accept a load when idle, release at frame wrap
  always_comb begin
    w_hsNext = r_hsState;
    case (r_hsState)
      HS_IDLE:    if (Load)        w_hsNext = HS_PENDING;
      HS_PENDING: if (w_frameWrap) w_hsNext = HS_IDLE;
      default:                     w_hsNext = HS_IDLE;
    endcase
  end

  // Capture accepted load data into the pending buffer
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_pendData <= '0;
      r_pendPts  <= '0;
    end else if ((r_hsState == HS_IDLE) && Load) begin
      r_pendData <= Data;
      r_pendPts  <= Points;
    end
  end

  // Promote pending data to the display buffer only at a frame boundary
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_dispData <= '0;
      r_dispPts  <= '0;
    end else if ((r_hsState == HS_PENDING) && w_frameWrap) begin
      r_dispData <= r_pendData;
      r_dispPts  <= r_pendPts;
    end
  end

  // One-cycle frame pulse, aligned with the display buffer update
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_frameDone <= 1'b0;
    end else begin
      r_frameDone <= w_frameWrap;
    end
  end

  assign Ready     = (r_hsState == HS_IDLE);
  assign FrameDone = r_frameDone;
  assign En        = r_en;
  assign Segs      = r_segs;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl: a time-based reference model plus
// directed scenarios, randomized loads and a single-digit active-low instance.
module tb_seg_scan_ctrl;

  localparam int TB_DIGITS = 6;
  localparam int TB_DIV    = 2;
  localparam int SLOT      = TB_DIV * 16;
  localparam int FRAME     = SLOT * TB_DIGITS;

  logic        Clock;
  logic        Reset;
  logic        Load;
  logic [23:0] Data;
  logic [5:0]  Points;
  logic [5:0]  DisplayEnables;
  logic [3:0]  Duty;
  logic        Ready;
  logic        FrameDone;
  logic [5:0]  En;
  logic [7:0]  Segs;

  logic        load1;
  logic [3:0]  data1;
  logic [0:0]  points1;
  logic [0:0]  enables1;
  logic [3:0]  duty1;
  logic        ready1;
  logic        frameDone1;
  logic [0:0]  en1;
  logic [7:0]  segs1;

  int checks;
  int failures;
  int litCount [TB_DIGITS];

  int          mK;
  logic        mReady;
  logic [23:0] mPend;
  logic [5:0]  mPendPts;
  logic [23:0] mDisp;
  logic [5:0]  mDispPts;
  logic [5:0]  expEn;
  logic [7:0]  expSegs;
  logic        expFd;
  logic        expFd1;

  seg_scan_ctrl #(
    .DIGITS     (TB_DIGITS),
    .CLK_DIV    (TB_DIV),
    .ACTIVE_LOW (1'b0)
  ) u_dut (
    .Clock          (Clock),
    .Reset          (Reset),
    .Load           (Load),
    .Data           (Data),
    .Points         (Points),
    .DisplayEnables (DisplayEnables),
    .Duty           (Duty),
    .Ready          (Ready),
    .FrameDone      (FrameDone),
    .En             (En),
    .Segs           (Segs)
  );

  seg_scan_ctrl #(
    .DIGITS     (1),
    .CLK_DIV    (TB_DIV),
    .ACTIVE_LOW (1'b1)
  ) u_dut1 (
    .Clock          (Clock),
    .Reset          (Reset),
    .Load           (load1),
    .Data           (data1),
    .Points         (points1),
    .DisplayEnables (enables1),
    .Duty           (duty1),
    .Ready          (ready1),
    .FrameDone      (frameDone1),
    .En             (en1),
    .Segs           (segs1)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Standard hex glyphs, active-high {g,f,e,d,c,b,a}
  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
      4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
      4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
      4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
    endcase
  endfunction

  // Strobe expected for the scan position reached after k clocks since reset
  function automatic logic [5:0] modelEn(input int k, input logic [5:0] ens, input logic [3:0] duty);
    int ticks = k / TB_DIV;
    int sub   = ticks % 16;
    int idx   = (ticks / 16) % TB_DIGITS;
    if (ens[idx] && (sub < int'(duty))) return 6'(1 << idx);
    return 6'd0;
  endfunction

  // Segments expected for the scan position reached after k clocks since reset
  function automatic logic [7:0] modelSegs(input int k, input logic [5:0] ens, input logic [3:0] duty,
                                           input logic [23:0] disp, input logic [5:0] pts);
    int ticks = k / TB_DIV;
    int sub   = ticks % 16;
    int idx   = (ticks / 16) % TB_DIGITS;
    if (ens[idx] && (sub < int'(duty))) return {pts[idx], glyph(disp[4*idx +: 4])};
    return 8'h00;
  endfunction

  // Reference model: elapsed-time scan position plus frame-buffered load handshake
  always @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      mK       <= 0;
      mReady   <= 1'b1;
      mPend    <= '0;
      mPendPts <= '0;
      mDisp    <= '0;
      mDispPts <= '0;
      expEn    <= '0;
      expSegs  <= 8'h00;
      expFd    <= 1'b0;
      expFd1   <= 1'b0;
    end else begin
      expEn   <= modelEn(mK, DisplayEnables, Duty);
      expSegs <= modelSegs(mK, DisplayEnables, Duty, mDisp, mDispPts);
      expFd   <= ((mK + 1) % FRAME == 0);
      expFd1  <= ((mK + 1) % SLOT == 0);
      if (mReady && Load) begin
        mPend    <= Data;
        mPendPts <= Points;
        mReady   <= 1'b0;
      end else if (!mReady && ((mK + 1) % FRAME == 0)) begin
        mDisp    <= mPend;
        mDispPts <= mPendPts;
        mReady   <= 1'b1;
      end
      mK <= mK + 1;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, actual, required, $time);
    end
  endtask

  // Every cycle out of reset, both instances are compared against the model
  always @(negedge Clock) begin
    if (!Reset) begin
      checkOutput("En", 32'(En), 32'(expEn));
      checkOutput("Segs", 32'(Segs), 32'(expSegs));
      checkOutput("FrameDone", 32'(FrameDone), 32'(expFd));
      checkOutput("Ready", 32'(Ready), 32'(mReady));
      checkOutput("En1", 32'(en1), 32'd1);
      checkOutput("Segs1", 32'(segs1), 32'hFF);
      checkOutput("Ready1", 32'(ready1), 32'd1);
      checkOutput("FrameDone1", 32'(frameDone1), 32'(expFd1));
    end
  end

  task automatic applyStimulus(input logic ld, input logic [23:0] d, input logic [5:0] p);
    @(negedge Clock);
    Load   = ld;
    Data   = d;
    Points = p;
  endtask

  task automatic waitFrameDone(output int cycles);
    cycles = 0;
    do begin
      @(negedge Clock);
      cycles++;
    end while (!FrameDone && cycles < 400);
    if (!FrameDone) begin
      checks++;
      failures++;
      $display("[TB] FAIL frameDoneTimeout actual=0 required=1 after %0d cycles", cycles);
    end
  endtask

  // Observe one full frame after a FrameDone, tallying lit cycles per digit
  task automatic countFrame(input bit pinDigits);
    int fdSeen = 0;
    for (int d = 0; d < TB_DIGITS; d++) litCount[d] = 0;
    for (int i = 1; i <= FRAME; i++) begin
      @(negedge Clock);
      for (int d = 0; d < TB_DIGITS; d++) if (En == 6'(1 << d)) litCount[d]++;
      if (FrameDone) fdSeen++;
      if (pinDigits && i == 1) begin
        checkOutput("pinEnDigit0", 32'(En), 32'h01);
        checkOutput("pinSegsDigit0", 32'(Segs), 32'h3F);
      end
      if (pinDigits && i == SLOT + 1) begin
        checkOutput("pinEnDigit1", 32'(En), 32'h02);
        checkOutput("pinSegsDigit1", 32'(Segs), 32'h06);
      end
    end
    checkOutput("frameDoneAtPeriod", 32'(FrameDone), 32'd1);
    checkOutput("frameDoneOncePerFrame", 32'(fdSeen), 32'd1);
  endtask

  initial begin
    int cyc;
    checks   = 0;
    failures = 0;
    Reset = 1'b1; Load = 1'b0; Data = '0; Points = '0;
    DisplayEnables = 6'h3F; Duty = 4'd15;
    load1 = 1'b0; data1 = 4'h7; points1 = 1'b1; enables1 = 1'b1; duty1 = 4'd0;

    repeat (3) @(negedge Clock);
    #2 Reset = 1'b0;
    #1;
    checkOutput("resetEn", 32'(En), 32'h00);
    checkOutput("resetSegs", 32'(Segs), 32'h00);
    checkOutput("resetReady", 32'(Ready), 32'd1);
    checkOutput("resetFrameDone", 32'(FrameDone), 32'd0);

    // All digits at near-full brightness with data 543210
    applyStimulus(1'b1, 24'h543210, 6'h00);
    applyStimulus(1'b0, 24'h000000, 6'h00);
    checkOutput("readyDropsAfterLoad", 32'(Ready), 32'd0);
    waitFrameDone(cyc);
    countFrame(1'b1);
    for (int d = 0; d < TB_DIGITS; d++) checkOutput($sformatf("litFull%0d", d), 32'(litCount[d]), 32'd30);

    // Alternate digits enabled at half duty
    DisplayEnables = 6'b101010; Duty = 4'd8;
    countFrame(1'b0);
    for (int d = 0; d < TB_DIGITS; d++)
      checkOutput($sformatf("litHalf%0d", d), 32'(litCount[d]), (d % 2 == 1) ? 32'd16 : 32'd0);

    // Mid-frame load followed by an ignored load while not ready
    DisplayEnables = 6'h3F; Duty = 4'd15;
    repeat (50) @(negedge Clock);
    Load = 1'b1; Data = 24'hABCDEF; Points = 6'b000001;
    @(negedge Clock);
    checkOutput("readyLowSecondLoad", 32'(Ready), 32'd0);
    Data = 24'($urandom); Points = 6'($urandom);
    applyStimulus(1'b0, 24'h000000, 6'h00);
    waitFrameDone(cyc);
    checkOutput("readyRisesAtFrameDone", 32'(Ready), 32'd1);

    // Load coincident with FrameDone shows only from the following frame
    Load = 1'b1; Data = 24'h00000C; Points = 6'h00;
    applyStimulus(1'b0, 24'h000000, 6'h00);
    checkOutput("firstLoadEn", 32'(En), 32'h01);
    checkOutput("firstLoadSegs", 32'(Segs), 32'hF1);
    waitFrameDone(cyc);
    checkOutput("framePeriod", 32'(cyc), 32'(FRAME - 1));
    @(negedge Clock);
    checkOutput("coincidentLoadEn", 32'(En), 32'h01);
    checkOutput("coincidentLoadSegs", 32'(Segs), 32'h39);

    // Randomized loads, enables, duty and points
    for (int c = 0; c < 1500; c++) begin
      @(negedge Clock);
      Load   = ($urandom_range(15) == 0);
      Data   = 24'($urandom);
      Points = 6'($urandom);
      if (c % 40 == 0) begin
        DisplayEnables = 6'($urandom);
        Duty           = 4'($urandom);
      end
    end
    applyStimulus(1'b0, 24'h000000, 6'h00);

    // Reset mid-slot while data is pending
    DisplayEnables = 6'h3F; Duty = 4'd15;
    cyc = 0;
    while (!Ready && cyc < 400) begin
      @(negedge Clock);
      cyc++;
    end
    checkOutput("readyBeforeReset", 32'(Ready), 32'd1);
    applyStimulus(1'b1, 24'h111111, 6'h00);
    applyStimulus(1'b0, 24'h000000, 6'h00);
    cyc = 0;
    while (En == 6'h00 && cyc < 64) begin
      @(negedge Clock);
      cyc++;
    end
    checkOutput("litBeforeReset", 32'(En != 6'h00), 32'd1);
    #3 Reset = 1'b1;
    #1;
    checkOutput("asyncResetEn", 32'(En), 32'h00);
    checkOutput("asyncResetSegs", 32'(Segs), 32'h00);
    checkOutput("asyncResetReady", 32'(Ready), 32'd1);
    checkOutput("asyncResetFrameDone", 32'(FrameDone), 32'd0);
    checkOutput("asyncResetSegs1", 32'(segs1), 32'hFF);
    repeat (2) @(negedge Clock);
    #2 Reset = 1'b0;
    @(negedge Clock);
    checkOutput("afterResetEn", 32'(En), 32'h01);
    checkOutput("afterResetSegs", 32'(Segs), 32'h3F);
    checkOutput("afterResetReady", 32'(Ready), 32'd1);
    waitFrameDone(cyc);
    @(negedge Clock);
    checkOutput("pendingDiscardedSegs", 32'(Segs), 32'h3F);
    repeat (10) @(negedge Clock);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 SHALL have parameter DIGITS, default 6, meaning the number of multiplexed digits (range 1..8).
REQ-002 SHALL have parameter CLK_DIV, default 50000, meaning Clock cycles per scan tick (at least 2).
REQ-003 SHALL have parameter ACTIVE_LOW, default 1, meaning 1 drives En/Segs active-low and 0 drives them active-high.
REQ-004 SHALL have port Clock, input, 1 bit: the single clock for the block.
REQ-005 SHALL have port Reset, input, 1 bit: reset is asynchronous and active-high.
REQ-006 SHALL have port Load, input, 1 bit: request to capture Data/Points.
REQ-007 SHALL have port Data, input, 4*DIGITS bits: hex nibble per digit; nibble i sits at bits [4i+3:4i].
REQ-008 SHALL have port Points, input, DIGITS bits: decimal point per digit.
REQ-009 SHALL have port DisplayEnables, input, DIGITS bits: 1 means the digit is shown; sampled live, not latched.
REQ-010 SHALL have port Duty, input, 4 bits: brightness; digit on for Duty/16 of its slot; sampled live.
REQ-011 SHALL have port Ready, output, 1 bit: high means Load will be accepted.
REQ-012 SHALL have port FrameDone, output, 1 bit: one-cycle pulse at each frame wrap.
REQ-013 SHALL have port En, output, DIGITS bits: digit strobes, at most one active.
REQ-014 SHALL have port Segs, output, 8 bits: {dp,g,f,e,d,c,b,a}.

Function
REQ-015 Prescaler SHALL count 0..CLK_DIV-1 and assert an internal tick in the cycle it equals CLK_DIV-1, then wrap to 0.
REQ-016 Each tick SHALL advance a 4-bit sub-slot counter (0..15), so one digit slot is 16 ticks.
REQ-017 When the sub-slot counter wraps 15->0, the digit index SHALL advance 0..DIGITS-1 and wrap to 0.
REQ-018 A frame SHALL be DIGITS slots; every slot consumes time whether enabled or not, giving constant refresh.
REQ-019 Digit i SHALL be lit iff index==i, DisplayEnables[i]==1, and sub-slot < Duty.
REQ-020 Duty=0 SHALL keep all digits dark; Duty=15 SHALL give 15/16 on-time.
REQ-021 While lit, Segs SHALL carry the hex glyph of the displayed nibble i, with dp=Points[i].
REQ-022 While unlit, Segs SHALL be all-off and En all-inactive.
REQ-023 Glyphs SHALL be 0-9, A, b, C, d, E, F in the standard 7-segment encoding.
REQ-024 En and Segs SHALL be registered and follow the counter state with exactly one Clock of latency, glitch-free.
REQ-025 ACTIVE_LOW=1 SHALL invert En and Segs at the output registers only; internal logic stays active-high.
REQ-026 Load with Ready=1 SHALL capture Data/Points into a pending register on that edge and drop Ready on the next cycle.
REQ-027 Load with Ready=0 SHALL be ignored, with no capture and no error.
REQ-028 Pending data SHALL be copied to the display register on the edge where the index wraps DIGITS-1->0; Ready SHALL return high the same edge.
REQ-029 Load in the same cycle as a frame wrap with Ready=1 SHALL be captured into pending and shown from the following frame; no tearing within a frame.
REQ-030 FrameDone SHALL pulse high for exactly one cycle coincident with each index wrap, independent of Load.
REQ-031 DIGITS=1 SHALL be legal: the index stays 0 and each slot wrap is a frame wrap.

Reset
REQ-032 Reset assertion SHALL immediately and asynchronously clear the prescaler, sub-slot counter, index, pending and display registers to 0.
REQ-033 During reset: En all-inactive, Segs all-off (polarity per ACTIVE_LOW), Ready=1, FrameDone=0.
REQ-034 Reset mid-frame or mid-handshake SHALL discard pending data; after release the scan restarts at digit 0, sub-slot 0.

Structure
REQ-035 Shared package seg_pkg SHALL hold the 16-entry glyph constants, the SEG_OFF constant, and the segment bit-order definition.
REQ-036 Sub-module seg_hex_decoder SHALL be a purely combinational 4-bit to 7-bit decode; all sequential logic stays in seg_scan_ctrl.

Verification (CLK_DIV=2, DIGITS=6, ACTIVE_LOW=0 unless stated)
REQ-037 Reset, then Load Data=24'h543210, Points=0, DisplayEnables=6'h3F, Duty=15 -> after the first frame wrap, En walks 000001..100000 every 32 cycles and Segs=glyph(0..5), each lit 30 of 32 cycles.
REQ-038 DisplayEnables=6'b101010, Duty=8 -> only En[1], En[3], En[5] ever active, each for 16 cycles per slot; frame period stays 192 cycles.
REQ-039 Load mid-frame, then a second Load while Ready=0 -> the first value appears exactly at the next FrameDone, the second is ignored, and Ready rises at FrameDone.
REQ-040 Load coincident with FrameDone -> new data appears at the following FrameDone; FrameDone is a single-cycle pulse every 192 cycles.
REQ-041 Reset asserted mid-slot -> outputs go inactive asynchronously; after release the first lit digit is En[0] and Ready=1.
REQ-042 ACTIVE_LOW=1, DIGITS=1, Duty=0 -> En=1'b1 and Segs=8'hFF constantly.
